// File: rtl/dm_lsu.sv
// Load/store unit: synchronous-read data RAM with byte-lane steering and
// extension, AdEL/AdES detection, and a req/ack port for a device window.
module dm_lsu #(
  parameter int          DATA_W = 32,
  parameter int          DEPTH  = 3072,
  parameter logic [31:0] DEV_LO = 32'h7F00,
  parameter logic [31:0] DEV_HI = 32'h7F43
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [4:0]        rsp_exc,
  output logic              dev_req,
  output logic              dev_we,
  output logic [31:0]       dev_addr,
  output logic [DATA_W-1:0] dev_wdata,
  input  logic [DATA_W-1:0] dev_rdata,
  input  logic              dev_ack,
  output logic [1:0]        state_dbg
);
  localparam int          LANES     = DATA_W / 8;
  localparam int          OFF_W     = $clog2(LANES);
  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * LANES);
  localparam logic        DWORD_OK  = (DATA_W == 64);
  localparam logic [4:0]  EXC_NONE  = 5'd0;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;
  localparam logic [4:0]  EXC_ADES  = 5'd5;

  // Handshake: a request is taken on a rising edge where req_valid & req_ready;
  // req_ready is high only in IDLE, and rsp_valid is a single-cycle pulse in RESP.
  typedef enum logic [1:0] {IDLE, RD, DEV, RESP} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [31:0]       addr_q;
  logic              we_q, signed_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q, data_q;
  logic [4:0]        exc_q;

  logic              accept, misaligned, in_dev, in_ram, bad, ram_we;
  logic [4:0]        acc_exc;
  logic [LANES-1:0]  size_mask, wr_be;
  logic [DATA_W-1:0] wr_data, shifted, ext;
  logic [OFF_W-1:0]  off_q;
  int                keep;
  logic              sbit;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign off_q     = addr_q[OFF_W-1:0];

  always_comb begin
    unique case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
    in_dev  = (req_addr >= DEV_LO) && (req_addr <= DEV_HI);
    in_ram  = (req_addr < RAM_BYTES);
    bad     = misaligned || ((req_size == 2'd3) && !DWORD_OK) ||
              (in_dev && (req_size != 2'd2)) || (!in_dev && !in_ram);
    acc_exc = bad ? (req_we ? EXC_ADES : EXC_ADEL) : EXC_NONE;
    ram_we  = accept && req_we && !bad && !in_dev;
  end

  // Store data is replicated so every lane holds the right-aligned value.
  always_comb begin
    unique case (req_size)
      2'd0: begin size_mask = LANES'(1);  wr_data = {LANES{req_wdata[7:0]}};        end
      2'd1: begin size_mask = LANES'(3);  wr_data = {(LANES/2){req_wdata[15:0]}};   end
      2'd2: begin size_mask = LANES'(15); wr_data = {(LANES/4){req_wdata[31:0]}};   end
      default: begin size_mask = '1;      wr_data = req_wdata;                      end
    endcase
    wr_be = size_mask << req_addr[OFF_W-1:0];
  end

  // Device read data is right-aligned; shifting it into lane position lets the
  // RAM and device paths share one extraction stage.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) mem[req_addr[OFF_W +: IDX_W]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (state == RD) data_q <= mem[addr_q[OFF_W +: IDX_W]];
    else if (state == DEV && dev_ack) data_q <= dev_rdata << {off_q, 3'b000};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      exc_q    <= EXC_NONE;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q   <= req_addr;
        we_q     <= req_we;
        size_q   <= req_size;
        signed_q <= req_signed;
        wdata_q  <= req_wdata;
        exc_q    <= acc_exc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req_valid) begin
        if (bad)          state_nxt = RESP;
        else if (in_dev)  state_nxt = DEV;
        else if (req_we)  state_nxt = RESP;
        else              state_nxt = RD;
      end
      RD:      state_nxt = RESP;
      DEV:     if (dev_ack) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shifted = data_q >> {off_q, 3'b000};
    unique case (size_q)
      2'd0:    begin keep = 8;      sbit = shifted[7];        end
      2'd1:    begin keep = 16;     sbit = shifted[15];       end
      2'd2:    begin keep = 32;     sbit = shifted[31];       end
      default: begin keep = DATA_W; sbit = shifted[DATA_W-1]; end
    endcase
    ext = '0;
    for (int i = 0; i < DATA_W; i++) ext[i] = (i < keep) ? shifted[i] : (signed_q & sbit);
  end

  assign rsp_valid = (state == RESP);
  assign rsp_rdata = (rsp_valid && !we_q && exc_q == EXC_NONE) ? ext : '0;
  assign rsp_exc   = rsp_valid ? exc_q : EXC_NONE;
  assign dev_req   = (state == DEV);
  assign dev_we    = dev_req & we_q;
  assign dev_addr  = dev_req ? addr_q : '0;
  assign dev_wdata = dev_req ? wdata_q : '0;
  assign state_dbg = state;
endmodule

// File: doc/dm_lsu.md
# dm_lsu

Parametrised load/store unit replacing the combinational data-memory stage of the P8 CPU. It owns a synchronous-read data RAM of configurable width and depth, performs byte-lane steering and sign/zero extension for byte/half/word (and doubleword at 64-bit width) accesses, and raises AdEL/AdES exception codes. Accesses that hit a configurable device window are forwarded to a peripheral port with a req/ack handshake. One access is outstanding at a time, behind a valid/ready request interface.

## Interface
- DATA_W, 32: data width, 32 or 64; LANES = DATA_W/8.
- DEPTH, 3072: RAM depth in DATA_W words; RAM covers [0, DEPTH*LANES-1].
- DEV_LO, 32'h7F00: first byte address of the device window.
- DEV_HI, 32'h7F43: last byte address of the device window.
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64).
- req_signed  in  1  sign-extend load result.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and exceptions.
- rsp_exc  out  5  0 none, 4 AdEL, 5 AdES.
- dev_req  out  1  device access pending.
- dev_we  out  1  device write.
- dev_addr  out  32  device byte address.
- dev_wdata  out  DATA_W  device write data, unshifted.
- dev_rdata  in  DATA_W  device read data.
- dev_ack  in  1  device completes the access this cycle.

## Operation
- Accept on rising edge with req_valid & req_ready; latch addr, we, size, signed, wdata.
- Exception check at accept, in priority order:
  - misaligned: addr mod (1<<size) != 0;
  - size 3 with DATA_W=32;
  - device-window access with size != 2;
  - address outside both RAM and the device window.
- Loads that fail the check report code 4; stores report code 5. No RAM write and no dev_req on any exception.
- Byte enables: size-wide mask shifted by addr[log2(LANES)-1:0]. Store data is replicated across all lanes; only enabled lanes are written.
- Load extraction: shift the read word right by 8*offset, keep 8<<size bits, then sign- or zero-extend per req_signed. Size = DATA_W ignores req_signed.
- FSM states: IDLE, RD, DEV, RESP.
  - IDLE, accept with exception -> RESP.
  - IDLE, accept store to RAM: write on the accept edge -> RESP.
  - IDLE, accept load from RAM -> RD.
  - IDLE, accept to the device window -> DEV.
  - RD: RAM word registered -> RESP.
  - DEV: hold dev_req, dev_we, dev_addr, dev_wdata until dev_ack. On ack, capture dev_rdata for loads -> RESP.
  - RESP: rsp_valid=1, then -> IDLE.
- dev_req is combinationally high in DEV only.

## Timing
- Reset (reset=0), asynchronous: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_exc=0, dev_req=0, dev_we=0, dev_addr=0, dev_wdata=0. RAM contents are unspecified.
- Accept at edge k:
  - store or exception: rsp_valid in cycle k+1;
  - RAM load: rsp_valid in cycle k+2;
  - device access: rsp_valid in the cycle after the dev_ack edge.
- rsp_valid has no backpressure and lasts exactly one cycle.
- Earliest next accept is the edge ending the RESP cycle. Throughput: one store per 2 cycles, one RAM load per 3 cycles.
- dev_ack outside DEV is ignored.
- dev_ack in the first DEV cycle completes the access. Device access minimum latency: accept -> rsp_valid in cycle k+2.
- Reset asserted mid-access aborts the access with no response; a RAM write already committed on the accept edge stays committed.
- Store to A followed immediately by a load of A returns the new data: the write completes before RD.

## Test plan
- DATA_W=32: sw 0x12345678 at 0x10, lb at 0x13 signed -> rsp_rdata 0x00000012, exc 0, rsp_valid in cycle k+2. lhu at 0x12 -> 0x00001234.
- sb 0xAB at 0x21, then lw at 0x20 (word previously 0) -> 0x0000AB00. Only lane 1 is written.
- lw at 0x6 -> exc 4, no RAM read, rsp_valid in cycle k+1. sh at 0x3 -> exc 5, RAM unchanged.
- Out-of-range and device-window size checks:
  - lw at 0x3000 (DEPTH=3072) -> exc 4.
  - sw at 0x7F04 -> dev_req held until dev_ack in the 3rd DEV cycle; rsp_valid follows with exc 0.
  - lb at 0x7F00 -> exc 5? No: load, so exc 4, with dev_req never asserted.
- DATA_W=64: sd 0x8877665544332211 at 0x8, then lh signed at 0xE -> 0xFFFFFFFFFFFF8877. sd at 0x4 -> exc 5.
- Assert reset while in DEV -> all outputs return to their reset values immediately. A new request is accepted on the first edge after release.
